// File: rtl/axi_addr_mux_arb.sv
// AXI address-channel (AR/AW) master-to-slave multiplexer with a round-robin arbiter,
// a registered copy of the winning beat, and a grant lock held until the response completes.
module axi_addr_mux_arb #(
    parameter int MASTER_CNT = 4,
    parameter int ID_BITS    = 4,
    parameter int ADDR_BITS  = 32,
    parameter int LEN_BITS   = 4,
    parameter int SIZE_BITS  = 3
) (
    input  logic                                        ACLK,
    input  logic                                        ARESETn,
    input  logic [MASTER_CNT-1:0][ID_BITS-1:0]          AID_M,
    input  logic [MASTER_CNT-1:0][ADDR_BITS-1:0]        AADDR_M,
    input  logic [MASTER_CNT-1:0][LEN_BITS-1:0]         ALEN_M,
    input  logic [MASTER_CNT-1:0][SIZE_BITS-1:0]        ASIZE_M,
    input  logic [MASTER_CNT-1:0][1:0]                  ABURST_M,
    input  logic [MASTER_CNT-1:0]                       AVALID_M,
    output logic [MASTER_CNT-1:0]                       AREADY_M,
    output logic [$clog2(MASTER_CNT)+ID_BITS-1:0]       AID_S,
    output logic [ADDR_BITS-1:0]                        AADDR_S,
    output logic [LEN_BITS-1:0]                         ALEN_S,
    output logic [SIZE_BITS-1:0]                        ASIZE_S,
    output logic [1:0]                                  ABURST_S,
    output logic                                        AVALID_S,
    input  logic                                        AREADY_S,
    input  logic                                        resp_done,
    output logic [MASTER_CNT-1:0]                       grant,
    output logic                                        busy
);

    localparam int MIDX_BITS = $clog2(MASTER_CNT);
    localparam logic [MIDX_BITS:0]   CNT_W    = (MIDX_BITS+1)'(MASTER_CNT);
    localparam logic [MIDX_BITS-1:0] LAST_IDX = MIDX_BITS'(MASTER_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR      = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [MIDX_BITS-1:0]            r_rr_ptr;
    logic [MASTER_CNT-1:0]           r_grant;
    logic                            r_avalid_s;
    logic [MIDX_BITS+ID_BITS-1:0]    r_aid_s;
    logic [ADDR_BITS-1:0]            r_aaddr_s;
    logic [LEN_BITS-1:0]             r_alen_s;
    logic [SIZE_BITS-1:0]            r_asize_s;
    logic [1:0]                      r_aburst_s;

    logic [MIDX_BITS:0]              w_sum  [MASTER_CNT];
    logic [MIDX_BITS-1:0]            w_cand [MASTER_CNT];
    logic                            w_found;
    logic [MIDX_BITS-1:0]            w_winner;
    logic [MIDX_BITS-1:0]            w_rr_next;
    logic                            w_capture;
    logic [MASTER_CNT-1:0]           w_aready_m;

    // Candidate gi is the master checked at offset gi from the round-robin pointer.
    generate
        for (genvar gi = 0; gi < MASTER_CNT; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, r_rr_ptr} + (MIDX_BITS+1)'(gi);
            assign w_cand[gi] = (w_sum[gi] >= CNT_W) ? MIDX_BITS'(w_sum[gi] - CNT_W)
                                                     : w_sum[gi][MIDX_BITS-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = MASTER_CNT - 1; k >= 0; k--) begin
            if (AVALID_M[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    assign w_rr_next = (w_winner == LAST_IDX) ? '0 : w_winner + MIDX_BITS'(1);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_aready_m   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_capture            = 1'b1;
                    w_aready_m[w_winner] = 1'b1;
                    w_state_next         = S_ADDR;
                end
            end
            S_ADDR: begin
                if (AREADY_S) begin
                    w_state_next = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (resp_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_avalid_s <= 1'b0;
            r_aid_s    <= '0;
            r_aaddr_s  <= '0;
            r_alen_s   <= '0;
            r_asize_s  <= '0;
            r_aburst_s <= '0;
        end else if (w_capture) begin
            r_aid_s    <= {w_winner, AID_M[w_winner]};
            r_aaddr_s  <= AADDR_M[w_winner];
            r_alen_s   <= ALEN_M[w_winner];
            r_asize_s  <= ASIZE_M[w_winner];
            r_aburst_s <= ABURST_M[w_winner];
            r_grant    <= MASTER_CNT'(1) << w_winner;
            r_rr_ptr   <= w_rr_next;
            r_avalid_s <= 1'b1;
        end else if (r_state == S_ADDR && AREADY_S) begin
            r_avalid_s <= 1'b0;
        end else if (r_state == S_WAIT_RESP && resp_done) begin
            r_grant    <= '0;
        end
    end

    // Ready is forced low while reset is asserted, whatever state precedes the reset edge.
    assign AREADY_M = w_aready_m & {MASTER_CNT{ARESETn}};
    assign AID_S    = r_aid_s;
    assign AADDR_S  = r_aaddr_s;
    assign ALEN_S   = r_alen_s;
    assign ASIZE_S  = r_asize_s;
    assign ABURST_S = r_aburst_s;
    assign AVALID_S = r_avalid_s;
    assign grant    = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_addr_mux_arb.sv
// Bench for axi_addr_mux_arb: directed scenarios then random traffic, all checked
// against a transaction-level owner/pending model of the arbiter.
module tb_axi_addr_mux_arb;

    localparam int N  = 4;
    localparam int IB = 4;
    localparam int AB = 32;
    localparam int LB = 4;
    localparam int SB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [N-1:0][IB-1:0]    aid_m;
    logic [N-1:0][AB-1:0]    aaddr_m;
    logic [N-1:0][LB-1:0]    alen_m;
    logic [N-1:0][SB-1:0]    asize_m;
    logic [N-1:0][1:0]       aburst_m;
    logic [N-1:0]            avalid_m;
    logic [N-1:0]            aready_m;
    logic [IB+1:0]           aid_s;
    logic [AB-1:0]           aaddr_s;
    logic [LB-1:0]           alen_s;
    logic [SB-1:0]           asize_s;
    logic [1:0]              aburst_s;
    logic                    avalid_s;
    logic                    aready_s;
    logic                    resp_done;
    logic [N-1:0]            grant;
    logic                    busy;

    axi_addr_mux_arb #(
        .MASTER_CNT (N),
        .ID_BITS    (IB),
        .ADDR_BITS  (AB),
        .LEN_BITS   (LB),
        .SIZE_BITS  (SB)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .AID_M     (aid_m),
        .AADDR_M   (aaddr_m),
        .ALEN_M    (alen_m),
        .ASIZE_M   (asize_m),
        .ABURST_M  (aburst_m),
        .AVALID_M  (avalid_m),
        .AREADY_M  (aready_m),
        .AID_S     (aid_s),
        .AADDR_S   (aaddr_s),
        .ALEN_S    (alen_s),
        .ASIZE_S   (asize_s),
        .ABURST_S  (aburst_s),
        .AVALID_S  (avalid_s),
        .AREADY_S  (aready_s),
        .resp_done (resp_done),
        .grant     (grant),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: owner = master holding the lock (-1 none); pending = beat not yet taken by slave.
    int            m_owner   = -1;
    bit            m_pending = 1'b0;
    int            m_rr      = 0;
    logic [IB+1:0] m_aid     = '0;
    logic [AB-1:0] m_addr    = '0;
    logic [LB-1:0] m_len     = '0;
    logic [SB-1:0] m_size    = '0;
    logic [1:0]    m_burst   = '0;
    int            grant_log[$];
    int            txn_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the model, advance the model across the next edge, take the edge.
    task automatic step();
        int            w;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_grant;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (w < 0 && avalid_m[idx]) w = idx;
        end
        exp_ready = (rst_n && m_owner < 0 && w >= 0) ? N'(1 << w) : '0;
        exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check_val("aready_m", 64'(aready_m), 64'(exp_ready));
        check_val("grant",    64'(grant),    64'(exp_grant));
        check_val("busy",     64'(busy),     64'(m_owner >= 0));
        check_val("avalid_s", 64'(avalid_s), 64'(m_pending));
        check_val("aid_s",    64'(aid_s),    64'(m_aid));
        check_val("aaddr_s",  64'(aaddr_s),  64'(m_addr));
        check_val("alen_s",   64'(alen_s),   64'(m_len));
        check_val("asize_s",  64'(asize_s),  64'(m_size));
        check_val("aburst_s", 64'(aburst_s), 64'(m_burst));
        if (!rst_n) begin
            m_owner = -1; m_pending = 1'b0; m_rr = 0;
            m_aid = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
        end else if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner   = w;
                m_pending = 1'b1;
                m_rr      = (w + 1) % N;
                m_aid     = {2'(w), aid_m[w]};
                m_addr    = aaddr_m[w];
                m_len     = alen_m[w];
                m_size    = asize_m[w];
                m_burst   = aburst_m[w];
                grant_log.push_back(w);
                txn_cnt++;
                $display("txn %0d: master %0d id=%h addr=%h len=%0d size=%0d burst=%0d",
                         txn_cnt, w, m_aid, m_addr, m_len, m_size, m_burst);
            end
        end else if (m_pending) begin
            if (aready_s) m_pending = 1'b0;
        end else if (resp_done) begin
            m_owner = -1;
        end
        @(posedge clk);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            aid_m[i]    = IB'($urandom);
            aaddr_m[i]  = $urandom;
            alen_m[i]   = LB'($urandom);
            asize_m[i]  = SB'($urandom);
            aburst_m[i] = 2'($urandom);
        end
    endtask

    initial begin
        int wait_cnt;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; aid_m = '0; aaddr_m = '0; alen_m = '0; asize_m = '0; aburst_m = '0;
        avalid_m = '0; aready_s = 1'b0; resp_done = 1'b0;
        repeat (2) @(posedge clk);

        // Single request from master 2
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst_n      = 1'b1;
            avalid_m   = (c == 0) ? 4'b0100 : 4'b0000;
            aaddr_m[2] = 32'h0001_0000;
            aid_m[2]   = 4'h5;
            aready_s   = 1'b1;
            resp_done  = (c == 5);
            #1;
            if (c == 0) check_val("single_ready", 64'(aready_m), 64'(4'b0100));
            if (c == 1) check_val("single_aid",   64'(aid_s),    64'(6'h25));
            if (c == 5) check_val("single_grant", 64'(grant),    64'(4'b0100));
            if (c == 6) check_val("single_idle",  64'(busy),     64'(0));
            step();
        end

        // Round robin from a fresh reset with every master requesting
        @(negedge clk); rst_n = 1'b0; avalid_m = '0; resp_done = 1'b0; #1; step();
        grant_log.delete();
        wait_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rst_n    = 1'b1;
            rand_payload();
            avalid_m = 4'hF;
            aready_s = 1'b1;
            if (m_owner >= 0 && !m_pending) wait_cnt++; else wait_cnt = 0;
            resp_done = (wait_cnt == 2);
            #1;
            step();
        end
        check_val("rr_count", 64'(grant_log.size() >= 5), 64'(1));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check_val("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));

        // Backpressure then reset mid-ADDR, then master 0 must win first
        @(negedge clk); rst_n = 1'b0; avalid_m = '0; resp_done = 1'b0; #1; step();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_n    = (c != 2);
            avalid_m = (c < 3) ? 4'b0010 : 4'b1111;
            aready_s = 1'b0;
            resp_done = (c == 1);
            #1;
            step();
        end
        @(negedge clk); avalid_m = '0; #1;
        check_val("post_reset_grant", 64'(grant), 64'(4'b0001));
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 79) != 0);
            rand_payload();
            avalid_m  = N'($urandom);
            aready_s  = ($urandom_range(0, 2) != 0);
            resp_done = ($urandom_range(0, 3) == 0);
            #1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
